// File: rtl/dice_roller.sv
// rtl/dice_roller.sv - key debounce, per-player die roll FSMs and round completion pulse
//
// Optional feature macro: LFSR_SCRAMBLE_EN
//   When defined, the frozen die value is offset by bits of a free-running
//   16-bit Galois LFSR. Player 1 uses lfsr[2:0] and player 2 uses lfsr[5:3].
//   When undefined, the die freezes at its rolling value and no LFSR exists.
//
// Ports (dice_roller):
//   clk         system clock
//   rst         asynchronous active-low reset
//   key1, key2  raw player buttons, active high, asynchronous to clk
//   busy        scorer busy; while high a new roll cannot start
//   start1/2    debounced key levels
//   dice1/2     die values, 0 = never rolled, else 1..6
//   rolling1/2  high while that player's die is rolling
//   round_done  one-cycle pulse once both dice are frozen

// Two-flop synchronizer followed by a stable-sample debounce counter.
// Ports: i_clk, i_rst_n, i_key (raw async key), o_level (debounced level).
module dice_roller_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_level
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // The counter only runs while the synced sample disagrees with the
  // accepted level; any agreeing sample restarts the stability window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= i_key;
      r_sync1 <= r_sync0;
      if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// Per-player roll FSM: IDLE -> ROLL on start rising (when not busy),
// ROLL -> READY on start falling, READY -> IDLE on i_clear.
// Ports: i_clk, i_rst_n, i_start (debounced key), i_busy, i_clear (round
// completion), i_scramble (LFSR bits, optional), o_die, o_rolling, o_ready.
module dice_roller_player #(
  parameter int ROLL_DIV = 1000,
  parameter int CNT_W    = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_busy,
  input  logic       i_clear,
`ifdef LFSR_SCRAMBLE_EN
  input  logic [2:0] i_scramble,
`endif
  output logic [3:0] o_die,
  output logic       o_rolling,
  output logic       o_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROLL  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(ROLL_DIV - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_start_d;
  logic [3:0]       r_die;
  logic [3:0]       w_die_nxt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] w_div_nxt;
  logic             w_rise;
  logic             w_fall;
  logic [3:0]       w_frozen;

  assign w_rise = i_start & ~r_start_d;
  assign w_fall = ~i_start & r_start_d;

`ifdef LFSR_SCRAMBLE_EN
  // ((die-1 + s) mod 6) + 1 with die-1 in 0..5 and s in 0..7, so the sum
  // is at most 12 and two conditional subtractions cover the modulo.
  logic [3:0] w_sum;
  always_comb begin
    w_sum = (r_die - 4'd1) + {1'b0, i_scramble};
    if (w_sum >= 4'd12) begin
      w_frozen = w_sum - 4'd11;
    end else if (w_sum >= 4'd6) begin
      w_frozen = w_sum - 4'd5;
    end else begin
      w_frozen = w_sum + 4'd1;
    end
  end
`else
  assign w_frozen = r_die;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_start_d <= 1'b0;
      r_die     <= 4'd0;
      r_div     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_d <= i_start;
      r_die     <= w_die_nxt;
      r_div     <= w_div_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_die_nxt   = r_die;
    w_div_nxt   = r_div;
    case (r_state)
      ST_IDLE: begin
        // A press seen while busy is simply lost; the edge is one cycle wide.
        if (w_rise && !i_busy) begin
          w_state_nxt = ST_ROLL;
          w_div_nxt   = '0;
          if (r_die == 4'd0) begin
            w_die_nxt = 4'd1;
          end
        end
      end
      ST_ROLL: begin
        // Release wins over a divider wrap in the same cycle so the value
        // the player saw is the one that freezes.
        if (w_fall) begin
          w_state_nxt = ST_READY;
          w_die_nxt   = w_frozen;
        end else if (r_div == DIV_LAST) begin
          w_div_nxt = '0;
          w_die_nxt = (r_die == 4'd6) ? 4'd1 : r_die + 4'd1;
        end else begin
          w_div_nxt = r_div + CNT_W'(1);
        end
      end
      ST_READY: begin
        if (i_clear) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_die     = r_die;
  assign o_rolling = (r_state == ST_ROLL);
  assign o_ready   = (r_state == ST_READY);

endmodule

module dice_roller #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int ROLL_DIV        = 1000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key1,
  input  logic       key2,
  input  logic       busy,
  output logic       start1,
  output logic       start2,
  output logic [3:0] dice1,
  output logic [3:0] dice2,
  output logic       rolling1,
  output logic       rolling2,
  output logic       round_done
);

  logic w_start1;
  logic w_start2;
  logic w_ready1;
  logic w_ready2;
  logic w_both;
  logic r_round_done;

  // Both FSMs leave READY on the same edge that raises round_done, so the
  // pulse drops by itself on the following cycle.
  assign w_both = w_ready1 & w_ready2;

`ifdef LFSR_SCRAMBLE_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_round_done <= 1'b0;
    end else begin
      r_round_done <= w_both;
    end
  end

  dice_roller_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db1 (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_key  (key1),
    .o_level(w_start1)
  );

  dice_roller_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db2 (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_key  (key2),
    .o_level(w_start2)
  );

  dice_roller_player #(
    .ROLL_DIV(ROLL_DIV),
    .CNT_W   (CNT_W)
  ) u_p1 (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_start   (w_start1),
    .i_busy    (busy),
    .i_clear   (w_both),
`ifdef LFSR_SCRAMBLE_EN
    .i_scramble(r_lfsr[2:0]),
`endif
    .o_die     (dice1),
    .o_rolling (rolling1),
    .o_ready   (w_ready1)
  );

  dice_roller_player #(
    .ROLL_DIV(ROLL_DIV),
    .CNT_W   (CNT_W)
  ) u_p2 (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_start   (w_start2),
    .i_busy    (busy),
    .i_clear   (w_both),
`ifdef LFSR_SCRAMBLE_EN
    .i_scramble(r_lfsr[5:3]),
`endif
    .o_die     (dice2),
    .o_rolling (rolling2),
    .o_ready   (w_ready2)
  );

  assign start1     = w_start1;
  assign start2     = w_start2;
  assign round_done = r_round_done;

endmodule

// File: tb/tb_dice_roller.sv
// tb/tb_dice_roller.sv - directed self-checking bench for dice_roller
module tb_dice_roller;

  logic       clk;
  logic       rst;
  logic       key1;
  logic       key2;
  logic       busy;
  logic       start1;
  logic       start2;
  logic [3:0] dice1;
  logic [3:0] dice2;
  logic       rolling1;
  logic       rolling2;
  logic       round_done;

  int n_vec;
  int n_err;
  int rd_count;
  int rd_mark;

  dice_roller #(
    .DEBOUNCE_CYCLES(4),
    .ROLL_DIV       (3),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key1      (key1),
    .key2      (key2),
    .busy      (busy),
    .start1    (start1),
    .start2    (start2),
    .dice1     (dice1),
    .dice2     (dice2),
    .rolling1  (rolling1),
    .rolling2  (rolling2),
    .round_done(round_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which round_done is high, sampled mid-cycle.
  always @(negedge clk) begin
    if (round_done === 1'b1) rd_count = rd_count + 1;
  end

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp)
    else begin
      n_err = n_err + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rd_count = 0;
    rst      = 1'b0;
    key1     = 1'b0;
    key2     = 1'b0;
    busy     = 1'b0;

    // Reset state
    tick(3);
    chk("rst_start1", start1, 0);
    chk("rst_start2", start2, 0);
    chk("rst_dice1", dice1, 0);
    chk("rst_dice2", dice2, 0);
    chk("rst_rolling", {rolling1, rolling2}, 0);
    chk("rst_round_done", round_done, 0);
    rst = 1'b1;
    tick(2);

    // Glitch of 2 cycles never reaches start1
    key1 = 1'b1;
    tick(2);
    key1 = 1'b0;
    tick(10);
    chk("glitch_start1", start1, 0);
    chk("glitch_rolling1", rolling1, 0);
    chk("glitch_dice1", dice1, 0);

    // Clean press: start1 rises on the 6th edge after the key edge (P0)
    key1 = 1'b1;
    tick(5);                                  // P5
    chk("db_before_latency", start1, 0);
    tick(1);                                  // P6
    chk("db_latency", start1, 1);
    chk("roll_not_yet", rolling1, 0);
    tick(1);                                  // P7: ROLL entry
    chk("roll_entry_rolling1", rolling1, 1);
    chk("roll_entry_dice1", dice1, 1);
    tick(3);                                  // P10
    chk("roll_step_dice1", dice1, 2);
    tick(15);                                 // P25: 2,3,4,5,6,1
    chk("roll_wrap_dice1", dice1, 1);
    chk("roll_wrap_rolling1", rolling1, 1);

    // Player 1 releases at 4, player 2 releases 10 cycles later at 2
    tick(4);                                  // P29
    key1 = 1'b0;
    tick(5);                                  // P34
    chk("p1_pre_release_dice1", dice1, 4);
    key2 = 1'b1;
    tick(2);                                  // P36: ready1
    chk("p1_frozen_rolling1", rolling1, 0);
    chk("p1_frozen_dice1", dice1, 4);
    chk("p1_start1_low", start1, 0);
    tick(3);                                  // P39
    key2 = 1'b0;
    tick(2);                                  // P41: ROLL2 entry
    chk("p2_roll_entry", {rolling2, dice2}, {1'b1, 4'd1});
    rd_mark = rd_count;
    tick(5);                                  // P46: ready2
    chk("p2_frozen_dice2", dice2, 2);
    chk("p2_frozen_rolling2", rolling2, 0);
    chk("rd_not_yet", round_done, 0);
    tick(1);                                  // P47
    chk("rd_pulse", round_done, 1);
    chk("rd_dice_hold", {dice1, dice2}, {4'd4, 4'd2});
    tick(1);
    chk("rd_pulse_end", round_done, 0);
    tick(5);
    chk("rd_single_pulse", rd_count - rd_mark, 1);

    // Simultaneous press and release from IDLE; dice keep previous values
    key1 = 1'b1;
    key2 = 1'b1;
    tick(7);                                  // S7: both ROLL
    chk("sim_rolling", {rolling1, rolling2}, 2'b11);
    chk("sim_keep_dice", {dice1, dice2}, {4'd4, 4'd2});
    rd_mark = rd_count;
    tick(3);                                  // S10
    key1 = 1'b0;
    key2 = 1'b0;
    tick(7);                                  // S17: both READY
    chk("sim_frozen_dice", {dice1, dice2}, {4'd1, 4'd5});
    chk("sim_frozen_rolling", {rolling1, rolling2}, 2'b00);
    chk("sim_rd_not_yet", round_done, 0);
    tick(1);                                  // S18
    chk("sim_rd_pulse", round_done, 1);
    tick(5);
    chk("sim_single_pulse", rd_count - rd_mark, 1);

    // Press while busy is dropped, not queued
    busy = 1'b1;
    key2 = 1'b1;
    tick(7);                                  // T7
    chk("busy_start2", start2, 1);
    chk("busy_rolling2", rolling2, 0);
    chk("busy_dice2", dice2, 5);
    busy = 1'b0;
    tick(3);                                  // T10
    chk("busy_not_queued", rolling2, 0);
    key2 = 1'b0;
    tick(8);                                  // T18
    key2 = 1'b1;
    tick(7);                                  // T25: second press rolls
    chk("repress_rolling2", rolling2, 1);
    chk("repress_dice2", dice2, 5);
    busy = 1'b1;
    tick(3);                                  // T28
    chk("busy_mid_roll_dice2", dice2, 6);
    chk("busy_mid_roll_rolling2", rolling2, 1);

    // Reset in the middle of a roll with dice1 = 3
    busy = 1'b0;
    key1 = 1'b1;
    tick(7);                                  // T35: ROLL1 entry, keeps 1
    chk("p1_again_dice1", dice1, 1);
    tick(6);                                  // T41
    chk("pre_reset_dice1", dice1, 3);
    rd_mark = rd_count;
    #2;
    rst = 1'b0;
    #2;
    chk("async_rst_dice1", dice1, 0);
    chk("async_rst_rolling1", rolling1, 0);
    chk("async_rst_start1", start1, 0);
    chk("async_rst_p2", {start2, rolling2, dice2}, 0);
    key1 = 1'b0;
    key2 = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(20);
    chk("post_rst_no_rd", rd_count - rd_mark, 0);
    chk("post_rst_dice1", dice1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
